// File: rtl/cntr_chk_pkg.sv
// Shared types for the counter checker: lock FSM states and sample classes.
package cntr_chk_pkg;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CLS_HOLD = 2'd0,
    CLS_STEP = 2'd1,
    CLS_JUMP = 2'd2
  } cls_e;

endpackage

// File: rtl/cntr_checker_sat_cntr.sv
// Saturating event counter; sticks at all-ones once reached.
module sat_cntr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cntr_checker.sv
// Watches an up-counter's output, locks after a run of legal samples and
// flags illegal jumps, observed counter resets and max->0 wraps.
module cntr_checker
  import cntr_chk_pkg::*;
#(
  parameter int DATA_WIDTH     = 2,
  parameter int LOCK_THRESHOLD = 2,
  parameter int ERR_CNT_WIDTH  = 8,
  parameter int WRAP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld,
  input  logic [DATA_WIDTH-1:0]     val,
  output logic                      en_dec,
  output logic                      locked,
  output logic                      err,
  output logic                      rst_seen,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt,
  output logic [WRAP_CNT_WIDTH-1:0] wrap_cnt
);

  localparam int RUN_W = $clog2(LOCK_THRESHOLD + 1);
  localparam logic [RUN_W-1:0]      RUN_LOCK = RUN_W'(LOCK_THRESHOLD);
  localparam logic [DATA_WIDTH-1:0] VAL_MAX  = '1;

  state_e                    state_q, state_d;
  logic [RUN_W-1:0]          run_q, run_d, run_inc;
  logic [DATA_WIDTH-1:0]     prev_q, prev_d, prev_inc;
  logic                      prev_valid_q, prev_valid_d;
  logic                      en_dec_q, en_dec_d;
  logic                      err_q, err_d;
  logic                      rst_seen_q, rst_seen_d;
  logic [WRAP_CNT_WIDTH-1:0] wrap_q, wrap_d;
  cls_e                      cls;

  assign prev_inc = prev_q + DATA_WIDTH'(1);
  assign run_inc  = run_q + RUN_W'(1);

  always_comb begin
    cls = CLS_JUMP;
    if (val == prev_q) begin
      cls = CLS_HOLD;
    end else if (val == prev_inc) begin
      cls = CLS_STEP;
    end
  end

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    en_dec_d     = 1'b0;
    err_d        = 1'b0;
    rst_seen_d   = 1'b0;
    wrap_d       = wrap_q;
    if (vld) begin
      prev_d       = val;
      prev_valid_d = 1'b1;
      // The very first sample only seeds prev; there is nothing to compare it to.
      if (prev_valid_q) begin
        en_dec_d = (cls == CLS_STEP);
        if (cls == CLS_STEP && prev_q == VAL_MAX) begin
          wrap_d = wrap_q + WRAP_CNT_WIDTH'(1);
        end
        case (state_q)
          ST_UNLOCKED: begin
            if (cls == CLS_JUMP) begin
              run_d = '0;
            end else if (run_inc >= RUN_LOCK) begin
              state_d = ST_LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end
          ST_LOCKED: begin
            if (cls == CLS_JUMP) begin
              // A jump to zero is the watched counter being reset, not a fault.
              if (val == '0) begin
                rst_seen_d = 1'b1;
              end else begin
                err_d   = 1'b1;
                state_d = ST_UNLOCKED;
                run_d   = '0;
              end
            end
          end
          default: state_d = ST_UNLOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_UNLOCKED;
      run_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      en_dec_q     <= 1'b0;
      err_q        <= 1'b0;
      rst_seen_q   <= 1'b0;
      wrap_q       <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      en_dec_q     <= en_dec_d;
      err_q        <= err_d;
      rst_seen_q   <= rst_seen_d;
      wrap_q       <= wrap_d;
    end
  end

  sat_cntr #(
    .WIDTH(ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .inc(err_d),
    .cnt(err_cnt)
  );

  assign en_dec   = en_dec_q;
  assign locked   = (state_q == ST_LOCKED);
  assign err      = err_q;
  assign rst_seen = rst_seen_q;
  assign wrap_cnt = wrap_q;

endmodule
